// File: rtl/tl_c_pkg.sv
// tl_c_pkg: TileLink C-channel opcodes, arbiter state encoding and beat-count helpers.
package tl_c_pkg;
    localparam int unsigned C_OP_W    = 3;
    localparam int unsigned C_PARAM_W = 3;
    typedef enum logic [C_OP_W-1:0] {
        ACCESS_ACK      = 3'd0,
        ACCESS_ACK_DATA = 3'd1,
        HINT_ACK        = 3'd2,
        PROBE_ACK       = 3'd4,
        PROBE_ACK_DATA  = 3'd5,
        RELEASE         = 3'd6,
        RELEASE_DATA    = 3'd7
    } tl_c_op_e;
    typedef enum logic {IDLE, BURST} arb_state_e;
    function automatic logic has_data(input logic [C_OP_W-1:0] op);
        return op[0];
    endfunction
    // Messages no larger than one beat still occupy a single beat.
    function automatic int unsigned num_beats(input int unsigned size, input int unsigned beat_bytes);
        int unsigned b;
        b = (32'd1 << size) / beat_bytes;
        return b == 0 ? 1 : b;
    endfunction
endpackage

// File: rtl/tl_c_channel_arbiter_rr_picker.sv
// rr_picker: combinational round-robin pick of the first requester at or after ptr_i, wrapping.
module rr_picker #(
    parameter int unsigned N  = 2,
    parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_oh_o,
    output logic [IW-1:0] gnt_idx_o
);
    // Lowest requester overall, then overridden by the lowest one at or above the pointer.
    always_comb begin
        gnt_idx_o = ptr_i;
        for (int i = N - 1; i >= 0; i--) if (req_i[i]) gnt_idx_o = IW'(i);
        for (int i = N - 1; i >= 0; i--) if (req_i[i] && IW'(i) >= ptr_i) gnt_idx_o = IW'(i);
    end
    assign gnt_oh_o = req_i & (N'(1) << gnt_idx_o);
endmodule

// File: rtl/tl_c_channel_arbiter.sv
// tl_c_channel_arbiter: round-robin share of one TileLink C channel, locking multibeat
// messages to their requester until the last beat; zero-latency forward path.
module tl_c_channel_arbiter
    import tl_c_pkg::*;
#(
    parameter int unsigned N_REQ    = 2,
    parameter int unsigned DATA_W   = 64,
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned SOURCE_W = 3,
    parameter int unsigned SIZE_W   = 4
) (
    input  logic                         clock_i,
    input  logic                         reset_i,
    input  logic [N_REQ-1:0]             in_valid_i,
    output logic [N_REQ-1:0]             in_ready_o,
    input  logic [N_REQ*C_OP_W-1:0]      in_opcode_i,
    input  logic [N_REQ*C_PARAM_W-1:0]   in_param_i,
    input  logic [N_REQ*SIZE_W-1:0]      in_size_i,
    input  logic [N_REQ*SOURCE_W-1:0]    in_source_i,
    input  logic [N_REQ*ADDR_W-1:0]      in_address_i,
    input  logic [N_REQ*DATA_W-1:0]      in_data_i,
    input  logic [N_REQ-1:0]             in_corrupt_i,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output logic [C_OP_W-1:0]            out_opcode_o,
    output logic [C_PARAM_W-1:0]         out_param_o,
    output logic [SIZE_W-1:0]            out_size_o,
    output logic [SOURCE_W-1:0]          out_source_o,
    output logic [ADDR_W-1:0]            out_address_o,
    output logic [DATA_W-1:0]            out_data_o,
    output logic                         out_corrupt_o,
    output logic                         busy_o
);
    localparam int unsigned IW         = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned BEAT_BYTES = DATA_W / 8;
    localparam int unsigned CNT_MAX    = 2 ** SIZE_W - 1;

    typedef struct packed {
        logic [C_OP_W-1:0]    opcode;
        logic [C_PARAM_W-1:0] param;
        logic [SIZE_W-1:0]    size;
        logic [SOURCE_W-1:0]  source;
        logic [ADDR_W-1:0]    address;
        logic [DATA_W-1:0]    data;
        logic                 corrupt;
    } beat_t;

    arb_state_e        state_q, state_d;
    logic [IW-1:0]     rr_ptr_q, rr_ptr_d, lock_id_q, lock_id_d, gnt_idx, sel;
    logic [SIZE_W-1:0] beat_cnt_q, beat_cnt_d, beats_m1;
    logic [N_REQ-1:0]  gnt_oh;
    int unsigned       extra;
    logic              fire;
    beat_t             lane [N_REQ];
    beat_t             cur;

    for (genvar g = 0; g < N_REQ; g++) begin : g_lane
        assign lane[g] = '{
            opcode:  in_opcode_i[g*C_OP_W +: C_OP_W],
            param:   in_param_i[g*C_PARAM_W +: C_PARAM_W],
            size:    in_size_i[g*SIZE_W +: SIZE_W],
            source:  in_source_i[g*SOURCE_W +: SOURCE_W],
            address: in_address_i[g*ADDR_W +: ADDR_W],
            data:    in_data_i[g*DATA_W +: DATA_W],
            corrupt: in_corrupt_i[g]
        };
    end

    rr_picker #(.N(N_REQ), .IW(IW)) u_pick (
        .req_i     (in_valid_i),
        .ptr_i     (rr_ptr_q),
        .gnt_oh_o  (gnt_oh),
        .gnt_idx_o (gnt_idx)
    );

    assign sel      = (state_q == BURST) ? lock_id_q : gnt_idx;
    assign cur      = lane[sel];
    assign fire     = out_valid_o & out_ready_i;
    assign extra    = has_data(cur.opcode) ? num_beats(32'(cur.size), BEAT_BYTES) - 1 : 0;
    assign beats_m1 = (extra > CNT_MAX) ? SIZE_W'(CNT_MAX) : SIZE_W'(extra);

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            lock_id_q  <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            lock_id_q  <= lock_id_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        lock_id_d  = lock_id_q;
        beat_cnt_d = beat_cnt_q;
        if (fire && state_q == IDLE) begin
            rr_ptr_d = (gnt_idx == IW'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
            if (beats_m1 != '0) begin
                state_d    = BURST;
                lock_id_d  = gnt_idx;
                beat_cnt_d = beats_m1;
            end
        end else if (fire) begin
            beat_cnt_d = beat_cnt_q - 1'b1;
            state_d    = (beat_cnt_q == SIZE_W'(1)) ? IDLE : BURST;
        end
    end

    always_comb begin
        busy_o        = state_q == BURST;
        out_valid_o   = busy_o ? in_valid_i[lock_id_q] : |in_valid_i;
        in_ready_o    = !out_ready_i ? '0 : busy_o ? N_REQ'(1) << lock_id_q : gnt_oh;
        out_opcode_o  = cur.opcode;
        out_param_o   = cur.param;
        out_size_o    = cur.size;
        out_source_o  = cur.source;
        out_address_o = cur.address;
        out_data_o    = cur.data;
        out_corrupt_o = cur.corrupt;
    end

    a_grant_only: assert property (@(posedge clock_i) disable iff (reset_i)
        (in_valid_i & in_ready_o & ~(N_REQ'(1) << sel)) == '0);
    a_burst_hdr: assert property (@(posedge clock_i) disable iff (reset_i)
        state_q == BURST && $past(state_q == BURST) |->
        $stable({cur.opcode, cur.size, cur.source, cur.address}));
endmodule
